// File: rtl/operand_skewer.sv
// rtl/operand_skewer.sv - buffers one N-step operand tile and replays it into N diagonally skewed lanes
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   upstream word valid
//   in_ready   word accepted this cycle when in_valid is also high
//   in_data    one tile step, lane i at [i*DATA_W +: DATA_W]
//   out_data   skewed lane operands, lane i at [i*DATA_W +: DATA_W]
//   out_valid  per-lane valid to the edge MAC
//   busy       high while a tile is streaming
//   tile_done  one-cycle pulse when a tile has drained
module operand_skewer #(
  parameter int N      = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  output logic                busy,
  output logic                tile_done
);

  // Counters cover 0..2N-1; slot index only needs 0..N-1.
  localparam int CW = $clog2(2 * N);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(N - 1);
  localparam logic [CW-1:0] LAST_T = CW'(2 * N - 1);

  typedef enum logic {S_LOAD, S_STREAM} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       k_q, k_d;
  logic [CW-1:0]       t_q, t_d;
  logic [N*DATA_W-1:0] out_data_q, out_data_d;
  logic [N-1:0]        out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                tile_done_q, tile_done_d;
  logic                accept;
  logic [CW-1:0]       idx;

  logic [N*DATA_W-1:0] buf_q [N];

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      k_q         <= '0;
      t_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      t_q         <= t_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Tile buffer carries no reset; its contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[k_q[KW-1:0]] <= in_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:   if (accept && k_q == LAST_K) state_d = S_STREAM;
      S_STREAM: if (t_q == LAST_T)           state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    in_ready    = (state_q == S_LOAD);
    accept      = in_valid && in_ready;
    k_d         = k_q;
    t_d         = t_q;
    out_data_d  = '0;
    out_valid_d = '0;
    busy_d      = 1'b0;
    tile_done_d = 1'b0;
    idx         = '0;

    if (state_q == S_LOAD) begin
      t_d = '0;
      if (accept) begin
        k_d = (k_q == LAST_K) ? '0 : k_q + CW'(1);
      end
    end else if (t_q == LAST_T) begin
      // Drain edge: outputs return to zero and the tile is reported done.
      tile_done_d = 1'b1;
      t_d         = '0;
    end else begin
      busy_d = 1'b1;
      t_d    = t_q + CW'(1);
      // Lane i replays word t-i, so each lane lags its neighbour by one step.
      for (int i = 0; i < N; i++) begin
        idx = t_q - CW'(i);
        if (t_q >= CW'(i) && idx < CW'(N)) begin
          out_valid_d[i]                   = 1'b1;
          out_data_d[i*DATA_W +: DATA_W]   = buf_q[idx[KW-1:0]][i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign tile_done = tile_done_q;

endmodule

// File: tb/tb_operand_skewer.sv
// tb/tb_operand_skewer.sv - directed self-checking bench for operand_skewer
module tb_operand_skewer;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic            busy;
  logic            tile_done;

  int tests_run = 0;
  int fails     = 0;

  operand_skewer #(.N(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .tile_done (tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Word k of a tile: lane i = off + 16*i + k + 1.
  function automatic logic [N*DW-1:0] word(input logic [7:0] off, input int k);
    logic [N*DW-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[i*DW +: DW] = off + 8'(16 * i + k + 1);
    return w;
  endfunction

  // Expected {tile_done, busy, out_valid, out_data} observed after stream edge t (t = 2N-1 is the drain edge).
  function automatic logic [N*DW+N+1:0] exp_vec(input logic [7:0] off, input int t);
    logic [N*DW-1:0] d;
    logic [N-1:0]    v;
    d = '0;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (t >= i && t - i < N) begin
        v[i]         = 1'b1;
        d[i*DW +: DW] = off + 8'(16 * i + (t - i) + 1);
      end
    end
    return {(t == 2 * N - 1), (t < 2 * N - 1), v, d};
  endfunction

  task automatic load_tile(input logic [7:0] off, input int gap);
    for (int k = 0; k < N; k++) begin
      if (k > 0) repeat (gap) step();
      in_valid = 1'b1;
      in_data  = word(off, k);
      step();
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    tests_run++;
    if ({in_ready, out_valid, out_data, busy, tile_done} !== {1'b1, 4'b0000, 32'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got rdy=%b v=%b d=%h busy=%b done=%b expected rdy=1 v=0000 d=0 busy=0 done=0",
               in_ready, out_valid, out_data, busy, tile_done);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [N*DW+N+1:0] got;
    load_tile(8'h00, 0);
    tests_run++;
    if ({in_ready, out_valid, busy} !== 6'b0_0000_0) begin
      fails++;
      $display("FAIL basic_after_load got rdy=%b v=%b busy=%b expected 0 0000 0", in_ready, out_valid, busy);
    end
    for (int t = 0; t < 2 * N; t++) begin
      step();
      got = {tile_done, busy, out_valid, out_data};
      tests_run++;
      if (got !== exp_vec(8'h00, t)) begin
        fails++;
        $display("FAIL basic t=%0d got %h expected %h", t, got, exp_vec(8'h00, t));
      end
      if (t == 0) begin
        tests_run++;
        if ({out_valid, out_data} !== {4'b0001, 32'h00000001}) begin
          fails++;
          $display("FAIL basic_step0 got %b %h expected 0001 00000001", out_valid, out_data);
        end
      end
      if (t == 3) begin
        tests_run++;
        if ({out_valid, out_data} !== {4'b1111, 32'h31221304}) begin
          fails++;
          $display("FAIL basic_step3 got %b %h expected 1111 31221304", out_valid, out_data);
        end
      end
      if (t == 6) begin
        tests_run++;
        if ({out_valid, out_data} !== {4'b1000, 32'h34000000}) begin
          fails++;
          $display("FAIL basic_step6 got %b %h expected 1000 34000000", out_valid, out_data);
        end
      end
      if (t == 2 * N - 1) begin
        tests_run++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL basic_drain_ready got %b expected 1", in_ready);
        end
      end
    end
    step();
    tests_run++;
    if ({tile_done, out_valid} !== 5'b0_0000) begin
      fails++;
      $display("FAIL basic_done_once got done=%b v=%b expected 0 0000", tile_done, out_valid);
    end
  endtask

  task automatic test_gapped();
    logic [N*DW+N+1:0] got;
    load_tile(8'h00, 2);
    tests_run++;
    if (out_valid !== 4'b0000) begin
      fails++;
      $display("FAIL gapped_pre_valid got %b expected 0000", out_valid);
    end
    for (int t = 0; t < 2 * N; t++) begin
      step();
      got = {tile_done, busy, out_valid, out_data};
      tests_run++;
      if (got !== exp_vec(8'h00, t)) begin
        fails++;
        $display("FAIL gapped t=%0d got %h expected %h", t, got, exp_vec(8'h00, t));
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [N*DW+N+1:0] got;
    load_tile(8'h00, 0);
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    for (int t = 0; t < 2 * N; t++) begin
      step();
      got = {tile_done, busy, out_valid, out_data};
      tests_run++;
      if (got !== exp_vec(8'h00, t) || in_ready !== (t == 2 * N - 1)) begin
        fails++;
        $display("FAIL backpressure t=%0d got %h rdy=%b expected %h rdy=%b",
                 t, got, in_ready, exp_vec(8'h00, t), (t == 2 * N - 1));
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [N*DW+N+1:0] got;
    load_tile(8'h00, 0);
    for (int t = 0; t < 2 * N; t++) begin
      step();
      got = {tile_done, busy, out_valid, out_data};
      tests_run++;
      if (got !== exp_vec(8'h00, t)) begin
        fails++;
        $display("FAIL b2b_tile1 t=%0d got %h expected %h", t, got, exp_vec(8'h00, t));
      end
    end
    // Second tile's word 0 presented in the tile_done cycle.
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data  = word(8'h80, k);
      tests_run++;
      if ({in_ready, out_valid} !== 5'b1_0000) begin
        fails++;
        $display("FAIL b2b_load k=%0d got rdy=%b v=%b expected 1 0000", k, in_ready, out_valid);
      end
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
    for (int t = 0; t < 2 * N; t++) begin
      step();
      got = {tile_done, busy, out_valid, out_data};
      tests_run++;
      if (got !== exp_vec(8'h80, t)) begin
        fails++;
        $display("FAIL b2b_tile2 t=%0d got %h expected %h", t, got, exp_vec(8'h80, t));
      end
    end
    step();
  endtask

  task automatic test_reset_mid_stream();
    logic [N*DW+N+1:0] got;
    load_tile(8'h00, 0);
    repeat (3) step();
    tests_run++;
    if (out_valid !== 4'b0111) begin
      fails++;
      $display("FAIL midrst_step2 got %b expected 0111", out_valid);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_data, busy, tile_done} !== 38'h0) begin
      fails++;
      $display("FAIL midrst_async got v=%b d=%h busy=%b done=%b expected all 0",
               out_valid, out_data, busy, tile_done);
    end
    step();
    reset = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, busy, out_valid} !== 6'b10_0000) begin
      fails++;
      $display("FAIL midrst_release got rdy=%b busy=%b v=%b expected 1 0 0000", in_ready, busy, out_valid);
    end
    step();
    load_tile(8'h40, 0);
    for (int t = 0; t < 2 * N; t++) begin
      step();
      got = {tile_done, busy, out_valid, out_data};
      tests_run++;
      if (got !== exp_vec(8'h40, t)) begin
        fails++;
        $display("FAIL midrst_fresh t=%0d got %h expected %h", t, got, exp_vec(8'h40, t));
      end
    end
    step();
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
